root_tx_arbiter: RTL
====================

ROOT_TX_ARBITER -- requirements
Module: root_tx_arbiter

Interface
REQ-001 SHALL have parameter DW, default 36, router packet width ({info[35:32], addr[31:16], data[15:0]}).
REQ-002 SHALL have parameter DEPTH, default 4, per-requester FIFO depth; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  3  per-requester packet valid; bit0 config/write path, bit1 rank UV path, bit2 activation path.
REQ-006 SHALL have port req_data  input  3*DW  per-requester packet; requester i occupies bits [i*DW +: DW].
REQ-007 SHALL have port req_rdy  output  3  per-requester ready; high when that FIFO is not full.
REQ-008 SHALL have port router_rdy  input  1  root router injection port can accept a packet this cycle.
REQ-009 SHALL have port tx_en  output  1  packet injected this cycle.
REQ-010 SHALL have port tx_data  output  DW  injected packet.
REQ-011 SHALL have port tx_grant  output  2  index of the granted requester when tx_en=1, else 0.
REQ-012 SHALL have port busy  output  1  high while any FIFO holds a packet.

Function
REQ-013 SHALL accept a packet from requester i on a rising edge where req_valid[i]=1 and req_rdy[i]=1, and push it into FIFO i.
REQ-014 SHALL derive req_rdy[i] only from registered occupancy (count_i < DEPTH), never from the pop of the same cycle; a full FIFO stays not-ready during the cycle it is popped.
REQ-015 SHALL ignore req_data[i] and leave FIFO i unchanged when req_valid[i]=1 and req_rdy[i]=0; the requester holds the packet.
REQ-016 SHALL make a pushed packet eligible for arbitration no earlier than the cycle after the push (no bypass path).
REQ-017 SHALL, when router_rdy=1 and at least one FIFO is non-empty, assert tx_en combinationally, drive tx_data from the head of the winning FIFO, and pop that FIFO on the same edge.
REQ-018 SHALL keep tx_en=0, tx_data=0 and tx_grant=0 when router_rdy=0 or all FIFOs are empty.
REQ-019 SHALL arbitrate round-robin over non-empty FIFOs using a 2-bit register last_grant; search order is (last+1) mod 3, (last+2) mod 3, last.
REQ-020 SHALL update last_grant to the winner only on cycles with tx_en=1.
REQ-021 SHALL grant at most one packet per cycle; throughput is one packet per cycle while router_rdy=1.
REQ-022 SHALL support simultaneous push and pop on the same FIFO in one cycle with occupancy unchanged and FIFO order preserved.
REQ-023 SHALL keep each FIFO strictly in order; per-requester order at tx equals acceptance order.
REQ-024 SHALL implement each FIFO with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a (log2(DEPTH)+1)-bit count.
REQ-025 SHALL drive busy = OR of (count_i != 0) from registered state.
REQ-026 SHALL guarantee starvation freedom: a non-empty FIFO is granted within 3 cycles in which router_rdy=1.

Reset
REQ-027 SHALL, on rst=1, asynchronously clear all FIFO pointers and counts to 0 and set last_grant to 2, so requester 0 has first priority.
REQ-028 SHALL discard any packets held in the FIFOs when rst is asserted mid-operation; FIFO storage arrays need not be reset.
REQ-029 SHALL drive req_rdy=3'b111, tx_en=0, tx_data=0, tx_grant=0 and busy=0 while rst=1 and in the first cycle after release.

Verification
REQ-030 SHALL cover: after reset, push A0 on req0 and B0 on req1 in the same cycle, router_rdy=1 -> next cycle tx A0 (grant 0), following cycle tx B0 (grant 1), then tx_en=0.
REQ-031 SHALL cover: all three FIFOs each hold 2 packets, router_rdy=1 -> grant sequence 0,1,2,0,1,2 over 6 consecutive cycles, and busy falls after the 6th.
REQ-032 SHALL cover: router_rdy=0 while 4 pushes go to req1 -> req_rdy[1]=0 after the 4th, a 5th valid is held and not accepted; raising router_rdy pops one, req_rdy[1]=1 the next cycle.
REQ-033 SHALL cover: with req2 FIFO at DEPTH-1, continuous push and pop on req2 for 10 cycles -> count stays DEPTH-1, packets exit in push order across pointer wrap.
REQ-034 SHALL cover: rst asserted with 3 packets queued -> tx_en=0, busy=0 and req_rdy=3'b111 immediately; no stale packet is injected after release.
REQ-035 SHALL cover: UV packet {info=UV, addr=16'h0005, data=16'h1234} on req1 -> tx_data equals 36'h{UV,0005,1234} bit-exact with tx_grant=1.

Source files
------------

// File: rtl/root_tx_arbiter.sv
// root_tx_arbiter: three per-requester FIFOs (config/write, rank UV, activation)
// merged round-robin onto the single root router injection port.
// A packet enters a FIFO on one edge and is eligible from the following cycle;
// the winning head is presented combinationally and popped on the same edge.
module root_tx_arbiter #(
  parameter int DW    = 36,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_valid,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_rdy,
  input  logic            router_rdy,
  output logic            tx_en,
  output logic [DW-1:0]   tx_data,
  output logic [1:0]      tx_grant,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  // Per-FIFO storage and registered bookkeeping.
  logic [DW-1:0] r_mem [3][DEPTH];
  logic [AW-1:0] r_wptr [3];
  logic [AW-1:0] r_rptr [3];
  logic [CW-1:0] r_count [3];
  logic [1:0]    r_last_grant;

  logic [2:0] w_nonempty;
  logic [2:0] w_push;
  logic [2:0] w_pop;
  logic [1:0] w_ord0;
  logic [1:0] w_ord1;
  logic [1:0] w_ord2;
  logic [1:0] w_win;
  logic       w_found;

  // Occupancy flags and handshakes, derived from registered counts only.
  always_comb begin
    w_nonempty = 3'b000;
    req_rdy    = 3'b000;
    w_push     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_nonempty[i] = (r_count[i] != {CW{1'b0}});
      req_rdy[i]    = (r_count[i] < FULL_C);
      w_push[i]     = req_valid[i] & req_rdy[i];
    end
    busy = |w_nonempty;
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_ord0  = 2'd0;
    w_ord1  = 2'd1;
    w_ord2  = 2'd2;
    w_found = 1'b0;
    w_win   = 2'd0;
    case (r_last_grant)
      2'd0: begin
        w_ord0 = 2'd1;
        w_ord1 = 2'd2;
        w_ord2 = 2'd0;
      end
      2'd1: begin
        w_ord0 = 2'd2;
        w_ord1 = 2'd0;
        w_ord2 = 2'd1;
      end
      default: begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
      end
    endcase
    if (w_nonempty[w_ord0]) begin
      w_found = 1'b1;
      w_win   = w_ord0;
    end else if (w_nonempty[w_ord1]) begin
      w_found = 1'b1;
      w_win   = w_ord1;
    end else if (w_nonempty[w_ord2]) begin
      w_found = 1'b1;
      w_win   = w_ord2;
    end else begin
      w_found = 1'b0;
      w_win   = 2'd0;
    end
  end

  // Injection port: winner's head goes out while the router can take it; else all zero.
  always_comb begin
    tx_en    = router_rdy & w_found;
    tx_data  = {DW{1'b0}};
    tx_grant = 2'd0;
    if (tx_en) begin
      tx_grant = w_win;
      case (w_win)
        2'd0:    tx_data = r_mem[0][r_rptr[0]];
        2'd1:    tx_data = r_mem[1][r_rptr[1]];
        2'd2:    tx_data = r_mem[2][r_rptr[2]];
        default: tx_data = {DW{1'b0}};
      endcase
    end else begin
      tx_grant = 2'd0;
      tx_data  = {DW{1'b0}};
    end
    w_pop = {tx_en & (w_win == 2'd2), tx_en & (w_win == 2'd1), tx_en & (w_win == 2'd0)};
  end

  // Pointer, count and last-grant state; reset drops queued packets and favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_wptr[i]  <= {AW{1'b0}};
        r_rptr[i]  <= {AW{1'b0}};
        r_count[i] <= {CW{1'b0}};
      end
      r_last_grant <= 2'd2;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PTR_ONE_C;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_ONE_C;
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + ONE_C;
          2'b01:   r_count[i] <= r_count[i] - ONE_C;
          default: r_count[i] <= r_count[i];
        endcase
      end
      if (tx_en) begin
        r_last_grant <= w_win;
      end
    end
  end

  // FIFO storage write; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= req_data[i*DW +: DW];
      end
    end
  end

endmodule
